// File: rtl/aileron_servo_ctrl_if.sv
// Command channel between the flight-command sequencer and the aileron
// servo controller.
//   cmd_angle : signed deflection request (W bits, two's complement)
//   cmd_valid : sequencer has a command on cmd_angle
//   cmd_ready : controller can take a command this cycle
// The master modport is the sequencer side, the slave modport the controller.
interface aileron_servo_ctrl_if #(
  parameter int W = 4
);
  logic signed [W-1:0] cmd_angle;
  logic                cmd_valid;
  logic                cmd_ready;

  modport master (output cmd_angle, output cmd_valid, input  cmd_ready);
  modport slave  (input  cmd_angle, input  cmd_valid, output cmd_ready);
endinterface

// File: rtl/aileron_servo_ctrl.sv
// Aileron actuator controller. Takes a clamped signed deflection command,
// slews the position register toward it by at most STEP every TICK_DIV
// clocks, decodes the position into the four valve drives, waits HOLD_CYC
// cycles once the target is reached and then pulses done.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   cmd    : command channel (cmd_angle / cmd_valid / cmd_ready), slave side
//   centre : level-sensitive emergency re-centre, overrides any command
//   pos    : current deflection, signed, registered
//   busy   : a move or settle interval is in progress
//   done   : one-cycle pulse when a move has settled
//   v1e/v1d: stage-1 valves (left when negative, right otherwise)
//   v2e/v2d: stage-2 valves (open at magnitudes of HI_THR and above)
module aileron_servo_ctrl #(
  parameter int W        = 4,
  parameter int LIMIT    = 7,
  parameter int HI_THR   = 4,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 4,
  parameter int HOLD_CYC = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  aileron_servo_ctrl_if.slave cmd,
  input  logic                centre,
  output logic signed [W-1:0] pos,
  output logic                busy,
  output logic                done,
  output logic                v1e,
  output logic                v1d,
  output logic                v2e,
  output logic                v2d
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [TW-1:0]        TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic signed [W-1:0]  LIM_P     = W'(LIMIT);
  localparam logic signed [W-1:0]  LIM_N     = W'(-LIMIT);
  localparam logic signed [W-1:0]  HI_P      = W'(HI_THR);
  localparam logic signed [W-1:0]  HI_N      = W'(-HI_THR);
  localparam logic signed [W-1:0]  ZERO      = '0;
  localparam logic signed [W-1:0]  STEP_W    = W'(STEP);
  localparam logic signed [W:0]    STEP_X    = (W+1)'(STEP);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  state_t              state;
  logic signed [W-1:0] target;
  logic [TW-1:0]       tick_cnt;
  logic [HW-1:0]       hold_cnt;

  logic signed [W-1:0] clamped;
  logic signed [W-1:0] step_pos;
  logic signed [W-1:0] move_pos;
  logic signed [W-1:0] move_tgt;
  logic signed [W:0]   diff;
  logic signed [W:0]   diff_mag;
  logic                ready;
  logic                accept;
  logic                tick_hit;

  // Saturate the incoming command into the legal deflection range.
  always_comb begin
    clamped = cmd.cmd_angle;
    if (cmd.cmd_angle > LIM_P)
      clamped = LIM_P;
    else if (cmd.cmd_angle < LIM_N)
      clamped = LIM_N;
  end

  // One slew step toward the current target. The difference is taken one bit
  // wider than the angle so that e.g. +7 - (-7) cannot wrap.
  always_comb begin
    diff     = {target[W-1], target} - {pos[W-1], pos};
    diff_mag = diff[W] ? -diff : diff;
    if (diff_mag <= STEP_X)
      step_pos = target;
    else if (diff[W])
      step_pos = pos - STEP_W;
    else
      step_pos = pos + STEP_W;
  end

  // Values pos and target take at the end of a MOVE cycle. The step uses the
  // target held before the edge; a retarget on the same edge counts from the
  // next tick onward.
  always_comb begin
    move_pos = tick_hit ? step_pos : pos;
    move_tgt = target;
    if (centre)
      move_tgt = ZERO;
    else if (accept)
      move_tgt = clamped;
  end

  assign tick_hit      = (tick_cnt == TICK_LAST);
  assign ready         = (state != HOLD) && !centre;
  assign accept        = cmd.cmd_valid && ready;
  assign cmd.cmd_ready = ready;
  assign busy          = (state != IDLE);

  // Valve decode straight off the position register, no extra latency.
  assign v1e = pos[W-1];
  assign v1d = ~pos[W-1];
  assign v2e = (pos <= HI_N);
  assign v2d = (pos >= HI_P);

  // Controller FSM. centre outranks any command in every state; a held centre
  // with the position already at zero lets the settle interval run out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pos      <= ZERO;
      target   <= ZERO;
      tick_cnt <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (centre) begin
            target <= ZERO;
            if (pos != ZERO) begin
              state    <= MOVE;
              tick_cnt <= '0;
            end
          end else if (accept) begin
            target   <= clamped;
            tick_cnt <= '0;
            if (clamped == pos) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              state <= MOVE;
            end
          end
        end
        MOVE: begin
          target   <= move_tgt;
          pos      <= move_pos;
          tick_cnt <= tick_hit ? '0 : tick_cnt + 1'b1;
          if (move_pos == move_tgt) begin
            state    <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (centre && (pos != ZERO)) begin
            target   <= ZERO;
            state    <= MOVE;
            tick_cnt <= '0;
          end else begin
            if (centre)
              target <= ZERO;
            if (hold_cnt == HOLD_LAST) begin
              state    <= IDLE;
              done     <= 1'b1;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aileron_servo_ctrl.sv
// Self-checking bench for aileron_servo_ctrl. A behavioural model of the
// servo (integer position, target and countdowns) is advanced once per clock
// and compared against every DUT output on each falling edge; directed
// scenarios add hand-computed literal expectations, followed by a randomized
// command/centre phase.
module tb_aileron_servo_ctrl;

  localparam int W        = 4;
  localparam int LIMIT    = 7;
  localparam int HI_THR   = 4;
  localparam int STEP     = 1;
  localparam int TICK_DIV = 4;
  localparam int HOLD_CYC = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                centre;
  logic signed [W-1:0] pos;
  logic                busy, done, v1e, v1d, v2e, v2d;

  aileron_servo_ctrl_if #(.W(W)) cmd_bus ();

  aileron_servo_ctrl #(
    .W(W), .LIMIT(LIMIT), .HI_THR(HI_THR), .STEP(STEP),
    .TICK_DIV(TICK_DIV), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd_bus),
    .centre(centre),
    .pos   (pos),
    .busy  (busy),
    .done  (done),
    .v1e   (v1e),
    .v1d   (v1d),
    .v2e   (v2e),
    .v2d   (v2d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state
  int m_pos, m_tgt, m_until, m_hold_left;
  bit m_moving, m_holding, m_done;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int clampAngle(input int a);
    if (a > LIMIT) return LIMIT;
    if (a < -LIMIT) return -LIMIT;
    return a;
  endfunction

  task automatic modelReset();
    m_pos = 0; m_tgt = 0; m_until = 0; m_hold_left = 0;
    m_moving = 1'b0; m_holding = 1'b0; m_done = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic modelEdge(input bit valid, input int angle, input bit cen);
    bit acc;
    int np, nt, d;
    acc = valid && !cen && !m_holding;
    m_done = 1'b0;
    if (m_holding) begin
      if (cen && m_pos != 0) begin
        m_tgt = 0; m_holding = 1'b0; m_moving = 1'b1; m_until = TICK_DIV;
      end else begin
        if (cen) m_tgt = 0;
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_holding = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (m_moving) begin
      np = m_pos;
      m_until--;
      if (m_until == 0) begin
        m_until = TICK_DIV;
        d = m_tgt - m_pos;
        if (d >= -STEP && d <= STEP) np = m_tgt;
        else if (d > 0)              np = m_pos + STEP;
        else                         np = m_pos - STEP;
      end
      nt = cen ? 0 : (acc ? clampAngle(angle) : m_tgt);
      m_pos = np;
      m_tgt = nt;
      if (np == nt) begin
        m_moving = 1'b0; m_holding = 1'b1; m_hold_left = HOLD_CYC;
      end
    end else begin
      if (cen) begin
        m_tgt = 0;
        if (m_pos != 0) begin
          m_moving = 1'b1; m_until = TICK_DIV;
        end
      end else if (acc) begin
        m_tgt = clampAngle(angle);
        if (m_tgt == m_pos) begin
          m_holding = 1'b1; m_hold_left = HOLD_CYC;
        end else begin
          m_moving = 1'b1; m_until = TICK_DIV;
        end
      end
    end
  endtask

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("pos",       int'(pos),               m_pos);
      checkOutput("cmd_ready", int'(cmd_bus.cmd_ready), (!m_holding && !centre) ? 1 : 0);
      checkOutput("busy",      int'(busy),              (m_moving || m_holding) ? 1 : 0);
      checkOutput("done",      int'(done),              m_done ? 1 : 0);
      checkOutput("v1e",       int'(v1e),               (m_pos < 0) ? 1 : 0);
      checkOutput("v1d",       int'(v1d),               (m_pos >= 0) ? 1 : 0);
      checkOutput("v2e",       int'(v2e),               (m_pos <= -HI_THR) ? 1 : 0);
      checkOutput("v2d",       int'(v2d),               (m_pos >= HI_THR) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input bit valid, input int angle, input bit cen);
    cmd_bus.cmd_valid = valid;
    cmd_bus.cmd_angle = W'(angle);
    centre = cen;
    @(posedge clk);
    #1;
    modelEdge(valid, angle, cen);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0);
  endtask

  // Run idle cycles until the controller drops busy, counting done pulses.
  task automatic waitDone(input string name, input int budget, output int pulses);
    bit finished;
    pulses = 0;
    finished = 1'b0;
    for (int i = 0; i < budget && !finished; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      if (done === 1'b1) pulses++;
      if (busy === 1'b0) finished = 1'b1;
    end
    checkOutput({name, "_finished"}, int'(finished), 1);
  endtask

  // Run idle cycles until pos reaches a value or the budget runs out.
  task automatic waitPos(input string name, input int value, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      if (int'(pos) == value) found = 1'b1;
    end
    checkOutput({name, "_reached"}, int'(found), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int a;
    bit v, c;

    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_angle = '0;
    centre = 1'b0;
    rst_n = 1'b0;
    modelReset();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state after ten idle cycles
    idleCycles(10);
    checkOutput("rst_pos",   int'(pos), 0);
    checkOutput("rst_v1d",   int'(v1d), 1);
    checkOutput("rst_v1e",   int'(v1e), 0);
    checkOutput("rst_v2e",   int'(v2e), 0);
    checkOutput("rst_v2d",   int'(v2d), 0);
    checkOutput("rst_ready", int'(cmd_bus.cmd_ready), 1);
    checkOutput("rst_busy",  int'(busy), 0);
    checkOutput("rst_done",  int'(done), 0);

    // +5 from zero: steps every four cycles, settle, done on cycle 23
    applyStimulus(1'b1, 5, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      applyStimulus(1'b0, 0, 1'b0);
      if (k == 3)  checkOutput("p5_k3_pos",  int'(pos), 0);
      if (k == 4)  checkOutput("p5_k4_pos",  int'(pos), 1);
      if (k == 8)  checkOutput("p5_k8_pos",  int'(pos), 2);
      if (k == 15) checkOutput("p5_k15_v2d", int'(v2d), 0);
      if (k == 16) checkOutput("p5_k16_v2d", int'(v2d), 1);
      if (k == 16) checkOutput("p5_k16_pos", int'(pos), 4);
      if (k == 20) checkOutput("p5_k20_pos", int'(pos), 5);
      if (k == 22) checkOutput("p5_k22_done", int'(done), 0);
      if (k == 23) checkOutput("p5_k23_done", int'(done), 1);
      if (k == 23) checkOutput("p5_k23_busy", int'(busy), 0);
      if (k == 24) checkOutput("p5_k24_done", int'(done), 0);
    end

    // -8 clamps to -7
    applyStimulus(1'b1, -8, 1'b0);
    waitDone("neg8", 100, pulses);
    checkOutput("neg8_pos",    int'(pos), -7);
    checkOutput("neg8_v1e",    int'(v1e), 1);
    checkOutput("neg8_v2e",    int'(v2e), 1);
    checkOutput("neg8_pulses", pulses, 1);

    // Heading for +7, retarget to +1 when passing +3
    applyStimulus(1'b1, 7, 1'b0);
    waitPos("retarget", 3, 100);
    applyStimulus(1'b1, 1, 1'b0);
    waitDone("retarget", 100, pulses);
    checkOutput("retarget_pos",    int'(pos), 1);
    checkOutput("retarget_pulses", pulses, 1);

    // Centre at +6 wins over a simultaneous command
    applyStimulus(1'b1, 6, 1'b0);
    waitDone("to6", 100, pulses);
    checkOutput("to6_pos", int'(pos), 6);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_angle = W'(2);
    centre = 1'b1;
    #1;
    checkOutput("centre_ready", int'(cmd_bus.cmd_ready), 0);
    applyStimulus(1'b1, 2, 1'b1);
    waitDone("centre", 100, pulses);
    checkOutput("centre_pos",    int'(pos), 0);
    checkOutput("centre_pulses", pulses, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 1'b1);
    checkOutput("centre_at_zero_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a move
    applyStimulus(1'b1, -5, 1'b0);
    waitPos("midreset", -3, 100);
    #1 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_pos",  int'(pos), 0);
    checkOutput("midreset_v1d",  int'(v1d), 1);
    checkOutput("midreset_busy", int'(busy), 0);
    #5 rst_n = 1'b1;
    idleCycles(10);

    // Randomized commands with occasional centre requests
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 39) == 0);
      a = int'($urandom_range(0, 15)) - 8;
      applyStimulus(v, a, c);
    end
    waitDone("final", 200, pulses);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aileron_servo_ctrl.md
Name: aileron_servo_ctrl

Overview:
Parametrised aileron actuator controller. It accepts a signed deflection command over a valid/ready handshake and slews an internal position register toward it at a fixed rate. It decodes the current position into the four valve drives (v1e, v1d, v2e, v2d), holds for a settle interval, then signals completion. It sits between the flight-command sequencer and the hydraulic valve drivers, and replaces the earlier purely combinational angle-to-valve decoder.

Parameters:
W, 4, angle width in bits, two's-complement signed
LIMIT, 7, maximum deflection magnitude; commands are clamped to [-LIMIT, +LIMIT]; must be <= 2^(W-1)-1
HI_THR, 4, magnitude at or above which the second-stage valve (v2e/v2d) opens
STEP, 1, maximum position change per slew tick; >= 1
TICK_DIV, 4, clock cycles per slew tick; >= 1
HOLD_CYC, 3, settle cycles after the target is reached, before done; >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_angle  in  W  commanded deflection, signed
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
centre  in  1  emergency re-centre request, level-sensitive
pos  out  W  current deflection, signed, registered
busy  out  1  high in MOVE or HOLD
done  out  1  one-cycle pulse on completion of a move
v1e  out  1  left stage-1 valve
v1d  out  1  right stage-1 valve
v2e  out  1  left stage-2 valve
v2d  out  1  right stage-2 valve

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pos=0, target=0, state IDLE, tick/hold counters=0, done=0.
  - Resulting outputs: cmd_ready=1, busy=0, v1d=1, v1e=0, v2e=0, v2d=0.
  - Reset mid-move abandons the move immediately; no done pulse is produced.
- Valve decode: combinational from the pos register, so there is no extra latency.
  - v1e = pos<0; v1d = pos>=0.
  - v2e = pos<=-HI_THR; v2d = pos>=HI_THR.
  - Exactly one of v1e/v1d is high at all times. v2e and v2d are never both high.
- Clamp: accepted cmd_angle is saturated to [-LIMIT,+LIMIT] before it is stored in target. With W=4, -8 is stored as -7.
- Arithmetic: the difference target-pos is computed at W+1 bits, so there is no overflow.
  - Per tick, if |diff| <= STEP then pos := target.
  - Otherwise pos := pos + sign(diff)*STEP.
- cmd_ready = 1 in IDLE and MOVE, 0 in HOLD.
- FSM states: IDLE, MOVE, HOLD.
- IDLE, on accept:
  - target := clamp(cmd_angle).
  - Tick counter cleared.
  - If the clamped value equals pos, go to HOLD; else go to MOVE.
- MOVE:
  - Tick counter counts 0..TICK_DIV-1. A step is applied on the edge where the counter equals TICK_DIV-1, and the counter wraps to 0 on that edge.
  - The first step lands TICK_DIV cycles after acceptance.
  - When the step makes pos == target, go to HOLD on the same edge and clear the hold counter.
  - Retarget: an accept in MOVE updates target without resetting the tick counter. If the new clamped target equals the current pos, go to HOLD immediately.
- HOLD:
  - Hold counter counts 0..HOLD_CYC-1.
  - On the edge where it equals HOLD_CYC-1: state := IDLE and done := 1.
  - done returns to 0 on the next edge.
- centre (sampled every edge, highest priority):
  - Forces target := 0 and overrides any simultaneous cmd_valid. That command is not accepted; cmd_ready is driven 0 while centre=1.
  - From IDLE with pos != 0: enter MOVE with the tick counter cleared.
  - From IDLE with pos == 0: no state change and no done pulse.
  - From MOVE: the move continues toward 0.
  - From HOLD: if pos != 0, re-enter MOVE with the tick counter cleared; otherwise stay in HOLD.
- Simultaneous events: the step is evaluated against the target value held before this edge. A retarget accepted on a step edge takes effect for the next tick.
- pos never leaves [-LIMIT,+LIMIT].

Test Plan:
- Reset, then hold idle 10 cycles -> pos=0, v1d=1, v1e=v2e=v2d=0, cmd_ready=1, busy=0, done=0.
- Defaults; accept cmd_angle=+5 at edge N -> pos increments by 1 at N+4, N+8, ..., reaching 5 at N+20. v2d rises when pos reaches 4 (N+16). done pulses at N+23 for one cycle, then state is IDLE.
- Accept cmd_angle=-8 (4'b1000) -> target=-7. v1e=1 from the first negative step. v2e=1 once pos<=-4. Final pos=-7.
- Moving toward +7, at pos=3 accept +1 -> pos steps down to 1 with no overshoot. Exactly one done pulse. No skipped tick: the tick phase is preserved.
- At pos=+6 in IDLE, assert centre with cmd_valid=1 and cmd_angle=+2 on the same cycle -> cmd_ready=0, command ignored, pos slews to 0, v1d stays 1, done pulses once.
- Move in progress at pos=-3; pull rst_n low for half a cycle -> immediately pos=0, v1d=1, busy=0. No done pulse afterwards.
